// File: rtl/lcd_pattern_gen_pkg.sv
// lcd_pkg: shared types and constants for the LCD test-pattern engine.
//   mode_e       - 3-bit pattern selector, six legal values
//   NUM_MODES    - number of legal patterns
//   rgb_flag_t   - full-scale on/off flag per colour channel
//   BAR_COLOR    - colour-bar palette, left to right
//   expand_flag  - replicate a channel flag to (up to) MAX_CH_BITS bits
package lcd_pkg;

  typedef enum logic [2:0] {
    M_BORDER   = 3'd0,
    M_SOLID    = 3'd1,
    M_BARS     = 3'd2,
    M_CHECKER  = 3'd3,
    M_GRADIENT = 3'd4,
    M_SCROLL   = 3'd5
  } mode_e;

  localparam int NUM_MODES   = 6;
  localparam int MAX_CH_BITS = 16;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_flag_t;

  localparam rgb_flag_t FLAG_WHITE = '{1'b1, 1'b1, 1'b1};

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_flag_t BAR_COLOR [8] = '{
    '{1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b0},
    '{1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b0, 1'b0}
  };

  function automatic logic [MAX_CH_BITS-1:0] expand_flag(input logic f);
    return {MAX_CH_BITS{f}};
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// lcd_pattern_gen_if: pixel path between LCD timing generator, pattern
// engine and panel pins.
//   X_IN/Y_IN, DE_IN/HSYNC_IN/VSYNC_IN - timing from the generator
//   LCD_R/G/B, LCD_DE/HSYNC/VSYNC      - registered panel outputs
//   master - timing-generator / panel side; slave - pattern engine
interface lcd_pattern_gen_if #(
  parameter int COORD_BITS = 10,
  parameter int R_BITS     = 5,
  parameter int G_BITS     = 6,
  parameter int B_BITS     = 5
);
  logic [COORD_BITS-1:0] X_IN;
  logic [COORD_BITS-1:0] Y_IN;
  logic                  DE_IN;
  logic                  HSYNC_IN;
  logic                  VSYNC_IN;
  logic [R_BITS-1:0]     LCD_R;
  logic [G_BITS-1:0]     LCD_G;
  logic [B_BITS-1:0]     LCD_B;
  logic                  LCD_DE;
  logic                  LCD_HSYNC;
  logic                  LCD_VSYNC;

  modport master (
    output X_IN, Y_IN, DE_IN, HSYNC_IN, VSYNC_IN,
    input  LCD_R, LCD_G, LCD_B, LCD_DE, LCD_HSYNC, LCD_VSYNC
  );

  modport slave (
    input  X_IN, Y_IN, DE_IN, HSYNC_IN, VSYNC_IN,
    output LCD_R, LCD_G, LCD_B, LCD_DE, LCD_HSYNC, LCD_VSYNC
  );
endinterface

// File: rtl/lcd_pattern_gen_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus debounce counter for an active-low
// push button.
//   CLK, RST - clock, synchronous active-high reset
//   BTN_N    - raw button, active-low, asynchronous
//   LEVEL    - debounced level (1 = released)
//   PRESS    - one-cycle pulse, registered, on debounced 1->0
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 333_333
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_N,
  output logic LEVEL,
  output logic PRESS
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= BTN_N;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_prev_q & ~level_q;
      // cnt_q counts consecutive cycles the synchronised input disagrees
      // with the accepted level; the level flips on the last of them.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: test-pattern engine for the RGB LCD path.
//   CLK, RST             - pixel clock, synchronous active-high reset
//   BTN_MODE, BTN_PAUSE  - raw active-low buttons
//   lcd (slave)          - timing in, registered colour/timing out
//   LED_R/G/B            - status LED, active-low, three-phase sequence
//   MODE                 - current pattern index
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int COORD_BITS      = 10,
  parameter int BORDER          = 10,
  parameter int R_BITS          = 5,
  parameter int G_BITS          = 6,
  parameter int B_BITS          = 5,
  parameter int CHECK_SHIFT     = 5,
  parameter int DEBOUNCE_CYCLES = 333_333,
  parameter int LED_PERIOD      = 24_000_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BTN_MODE,
  input  logic                BTN_PAUSE,
  lcd_pattern_gen_if.slave    lcd,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic [2:0]          MODE
);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [COORD_BITS-1:0] BORDER_C   = COORD_BITS'(BORDER);
  localparam logic [COORD_BITS-1:0] RIGHT_C    = COORD_BITS'(H_ACTIVE - BORDER);
  localparam logic [COORD_BITS-1:0] BOTTOM_C   = COORD_BITS'(V_ACTIVE - BORDER);
  localparam logic [COORD_BITS-1:0] BARS_END_C = COORD_BITS'(8 * BAR_W);
  localparam logic [2:0]            LAST_MODE  = 3'(NUM_MODES - 1);

  localparam int LED_W = (LED_PERIOD > 1) ? $clog2(LED_PERIOD) : 1;
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_PERIOD - 1);
  localparam logic [LED_W-1:0] PH1_C    = LED_W'(LED_PERIOD / 3);
  localparam logic [LED_W-1:0] PH2_C    = LED_W'(2 * (LED_PERIOD / 3));

  logic mode_level, mode_press, pause_level, pause_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .CLK(CLK), .RST(RST), .BTN_N(BTN_MODE), .LEVEL(mode_level), .PRESS(mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
    .CLK(CLK), .RST(RST), .BTN_N(BTN_PAUSE), .LEVEL(pause_level), .PRESS(pause_press)
  );

  // ---------------- mode FSM ----------------
  mode_e mode_q, mode_d;

  always_ff @(posedge CLK) begin
    if (RST) mode_q <= M_BORDER;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_q > LAST_MODE) begin
      mode_d = M_BORDER;
    end else if (mode_press) begin
      mode_d = (mode_q == LAST_MODE) ? M_BORDER : mode_e'(mode_q + 3'd1);
    end
  end

  // ---------------- pause, scroll, LED counter ----------------
  logic                  paused_q;
  logic [COORD_BITS-1:0] scroll_q;
  logic [LED_W-1:0]      led_cnt_q;
  logic                  frame_tick;

  assign frame_tick = lcd.DE_IN && (lcd.X_IN == '0) && (lcd.Y_IN == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      paused_q  <= 1'b0;
      scroll_q  <= '0;
      led_cnt_q <= '0;
    end else begin
      if (pause_press) paused_q <= ~paused_q;
      if (frame_tick && !paused_q) scroll_q <= scroll_q + 1'b1;
      if (!paused_q) led_cnt_q <= (led_cnt_q == LED_LAST) ? '0 : led_cnt_q + 1'b1;
    end
  end

  assign LED_R = (led_cnt_q >= PH1_C);
  assign LED_G = !((led_cnt_q >= PH1_C) && (led_cnt_q < PH2_C));
  assign LED_B = (led_cnt_q < PH2_C);
  assign MODE  = mode_q;

  // ---------------- pattern mux ----------------
  rgb_flag_t         flags;
  logic              use_grad;
  logic [2:0]        bar_idx;
  logic              scroll_carry;
  logic [R_BITS-1:0] pix_r;
  logic [G_BITS-1:0] pix_g;
  logic [B_BITS-1:0] pix_b;

  // Bit CHECK_SHIFT of (X + scroll) is X[k] ^ scroll[k] ^ carry-in; the carry
  // out of the low k bits is set exactly when X_low > ~scroll_low.
  assign scroll_carry = (lcd.X_IN[CHECK_SHIFT-1:0] > ~scroll_q[CHECK_SHIFT-1:0]);

  always_comb begin
    flags    = '0;
    use_grad = 1'b0;
    bar_idx  = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (lcd.X_IN >= COORD_BITS'(i * BAR_W)) bar_idx = 3'(i);
    end
    case (mode_q)
      M_BORDER:
        if (lcd.X_IN < BORDER_C || lcd.X_IN >= RIGHT_C ||
            lcd.Y_IN < BORDER_C || lcd.Y_IN >= BOTTOM_C) flags = FLAG_WHITE;
      M_SOLID:    flags = FLAG_WHITE;
      M_BARS:     if (lcd.X_IN < BARS_END_C) flags = BAR_COLOR[bar_idx];
      M_CHECKER:  if (!(lcd.X_IN[CHECK_SHIFT] ^ lcd.Y_IN[CHECK_SHIFT])) flags = FLAG_WHITE;
      M_GRADIENT: use_grad = 1'b1;
      M_SCROLL:
        if (!(lcd.X_IN[CHECK_SHIFT] ^ scroll_q[CHECK_SHIFT] ^ scroll_carry ^
              lcd.Y_IN[CHECK_SHIFT])) flags = FLAG_WHITE;
      default: ;
    endcase

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (lcd.DE_IN) begin
      if (use_grad) begin
        pix_r = lcd.X_IN[COORD_BITS-1 -: R_BITS];
        pix_g = lcd.X_IN[COORD_BITS-1 -: G_BITS];
        pix_b = lcd.X_IN[COORD_BITS-1 -: B_BITS];
      end else begin
        pix_r = R_BITS'(expand_flag(flags.r));
        pix_g = G_BITS'(expand_flag(flags.g));
        pix_b = B_BITS'(expand_flag(flags.b));
      end
    end
  end

  // ---------------- output register ----------------
  logic [R_BITS-1:0] r_q;
  logic [G_BITS-1:0] g_q;
  logic [B_BITS-1:0] b_q;
  logic              de_q, hs_q, vs_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= pix_r;
      g_q  <= pix_g;
      b_q  <= pix_b;
      de_q <= lcd.DE_IN;
      hs_q <= lcd.HSYNC_IN;
      vs_q <= lcd.VSYNC_IN;
    end
  end

  assign lcd.LCD_R     = r_q;
  assign lcd.LCD_G     = g_q;
  assign lcd.LCD_B     = b_q;
  assign lcd.LCD_DE    = de_q;
  assign lcd.LCD_HSYNC = hs_q;
  assign lcd.LCD_VSYNC = vs_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen with short debounce (4) and LED period (6).
module tb_lcd_pattern_gen;
  localparam int H  = 800;
  localparam int V  = 480;
  localparam int BD = 10;
  localparam int DB = 4;

  localparam int BAR_R [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  localparam int BAR_G [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  localparam int BAR_B [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  logic       CLK, RST, BTN_MODE, BTN_PAUSE;
  logic       LED_R, LED_G, LED_B;
  logic [2:0] MODE;

  int checks   = 0;
  int failures = 0;
  int mode_m, scroll_m;
  bit paused_m;

  lcd_pattern_gen_if #(.COORD_BITS(10), .R_BITS(5), .G_BITS(6), .B_BITS(5)) lcd_if ();

  lcd_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COORD_BITS(10), .BORDER(BD),
    .R_BITS(5), .G_BITS(6), .B_BITS(5), .CHECK_SHIFT(5),
    .DEBOUNCE_CYCLES(DB), .LED_PERIOD(6)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_PAUSE(BTN_PAUSE),
    .lcd(lcd_if), .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B), .MODE(MODE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected {R,G,B} for one pixel, straight from the pattern definitions.
  function automatic logic [15:0] ref_px(input int mode, input int x, input int y,
                                         input int scr, input bit de);
    int r, g, b, idx, xs;
    bit w;
    r = 0; g = 0; b = 0; w = 0;
    if (!de) return 16'h0000;
    case (mode)
      0: w = (x < BD) || (x >= H - BD) || (y < BD) || (y >= V - BD);
      1: w = 1;
      2: begin
        idx = x / (H / 8);
        if (x < 8 * (H / 8)) begin
          r = BAR_R[idx] * 31; g = BAR_G[idx] * 63; b = BAR_B[idx] * 31;
        end
      end
      3: w = (((x / 32) ^ (y / 32)) % 2) == 0;
      4: begin r = x / 32; g = x / 16; b = x / 32; end
      default: begin
        xs = (x + scr) % 1024;
        w  = (((xs / 32) ^ (y / 32)) % 2) == 0;
      end
    endcase
    if (w) begin r = 31; g = 63; b = 31; end
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic do_reset;
    @(negedge CLK);
    RST = 1'b1; BTN_MODE = 1'b1; BTN_PAUSE = 1'b1;
    lcd_if.DE_IN = 1'b0; lcd_if.X_IN = '0; lcd_if.Y_IN = '0;
    lcd_if.HSYNC_IN = 1'b0; lcd_if.VSYNC_IN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mode_m = 0; scroll_m = 0; paused_m = 0;
  endtask

  // Clean press of the selected button(s); pixel timing idles meanwhile.
  task automatic press(input bit m, input bit p);
    @(negedge CLK);
    lcd_if.DE_IN = 1'b0;
    if (m) BTN_MODE = 1'b0;
    if (p) BTN_PAUSE = 1'b0;
    repeat (10) @(negedge CLK);
    BTN_MODE = 1'b1; BTN_PAUSE = 1'b1;
    repeat (10) @(negedge CLK);
    if (m) mode_m = (mode_m + 1) % 6;
    if (p) paused_m = !paused_m;
  endtask

  // Drive one pixel, return expected and observed {RGB,DE,HS,VS} one cycle later.
  task automatic step_px(input int x, input int y, input bit de, input bit hs, input bit vs,
                         output logic [18:0] e, output logic [18:0] g);
    @(negedge CLK);
    lcd_if.X_IN = 10'(x); lcd_if.Y_IN = 10'(y); lcd_if.DE_IN = de;
    lcd_if.HSYNC_IN = hs; lcd_if.VSYNC_IN = vs;
    e = {ref_px(mode_m, x, y, scroll_m, de), de, hs, vs};
    if (de && x == 0 && y == 0 && !paused_m) scroll_m = (scroll_m + 1) % 1024;
    @(posedge CLK);
    #1;
    g = {lcd_if.LCD_R, lcd_if.LCD_G, lcd_if.LCD_B, lcd_if.LCD_DE, lcd_if.LCD_HSYNC, lcd_if.LCD_VSYNC};
  endtask

  task automatic test_reset;
    logic [18:0] e, g;
    do_reset;
    g = {lcd_if.LCD_R, lcd_if.LCD_G, lcd_if.LCD_B, lcd_if.LCD_DE, lcd_if.LCD_HSYNC, lcd_if.LCD_VSYNC};
    checks++;
    if (g !== 19'b0000000000000000_0_1_1) begin
      failures++; $display("FAIL reset_lcd got=%h exp=%h", g, 19'h3);
    end
    checks++;
    if ({MODE, LED_R, LED_G, LED_B} !== 6'b000_011) begin
      failures++; $display("FAIL reset_mode_led got=%b exp=%b", {MODE, LED_R, LED_G, LED_B}, 6'b000011);
    end
    step_px(5, 100, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'hFFFF || g !== e) begin
      failures++; $display("FAIL border_white got=%h exp=%h", g, e);
    end
    step_px(400, 240, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'h0000 || g !== e) begin
      failures++; $display("FAIL border_inner got=%h exp=%h", g, e);
    end
    checks++;
    if (MODE !== 3'd0 || LED_R === 1'bx) begin
      failures++; $display("FAIL mode_after_px got=%0d exp=0", MODE);
    end
  endtask

  task automatic test_debounce;
    int unsigned dur [5] = '{3, 3, 2, 2, 12};
    do_reset;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge CLK); BTN_MODE = 1'b0;
      repeat (3) @(negedge CLK);
      BTN_MODE = 1'b1;
      repeat (6) @(negedge CLK);
    end
    checks++;
    if (MODE !== 3'd0) begin
      failures++; $display("FAIL glitch_mode got=%0d exp=0", MODE);
    end
    BTN_MODE = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (MODE !== ((i >= 8) ? 3'd1 : 3'd0)) begin
        failures++; $display("FAIL press_latency edge=%0d got=%0d exp=%0d", i, MODE, (i >= 8) ? 1 : 0);
      end
    end
    repeat (12) @(posedge CLK);
    #1;
    checks++;
    if (MODE !== 3'd1) begin
      failures++; $display("FAIL held_once got=%0d exp=1", MODE);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge CLK);
      BTN_MODE = (i % 2 == 0);
      repeat (dur[i] - 1) @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (MODE !== 3'd1) begin
      failures++; $display("FAIL release_bounce got=%0d exp=1", MODE);
    end
    mode_m = 1;
    for (int unsigned p = 0; p < 5; p++) begin
      press(1, 0);
      checks++;
      if (MODE !== 3'(mode_m)) begin
        failures++; $display("FAIL mode_step got=%0d exp=%0d", MODE, mode_m);
      end
    end
  endtask

  task automatic test_patterns;
    logic [18:0] e, g;
    int x, y;
    bit de;
    do_reset;
    for (int unsigned m = 0; m < 6; m++) begin
      for (int unsigned n = 0; n < 40; n++) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 511);
        de = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin x = 0; y = 0; de = 1; end
        step_px(x, y, de, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, e, g);
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL rand_px mode=%0d x=%0d y=%0d de=%0d got=%h exp=%h", mode_m, x, y, de, g, e);
        end
      end
      press(1, 0);
    end
    checks++;
    if (MODE !== 3'd0) begin
      failures++; $display("FAIL mode_wrap got=%0d exp=0", MODE);
    end
  endtask

  task automatic test_bars;
    logic [18:0] e, g;
    int xs [4] = '{250, 150, 799, 805};
    do_reset;
    press(1, 0); press(1, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      step_px(xs[i], 10, 1, 0, 1, e, g);
      checks++;
      if (g !== e || (i == 0 && g[18:3] !== 16'h07FF)) begin
        failures++; $display("FAIL bars x=%0d got=%h exp=%h", xs[i], g, e);
      end
    end
  endtask

  task automatic test_scroll;
    logic [18:0] e, g;
    do_reset;
    repeat (5) press(1, 0);
    repeat (3) step_px(0, 0, 1, 1, 1, e, g);
    step_px(29, 0, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'h0000 || g !== e) begin
      failures++; $display("FAIL scroll_x29 got=%h exp=%h", g, e);
    end
    step_px(28, 0, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'hFFFF || g !== e) begin
      failures++; $display("FAIL scroll_x28 got=%h exp=%h", g, e);
    end
    press(0, 1);
    repeat (2) step_px(0, 0, 1, 1, 1, e, g);
    step_px(28, 0, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'hFFFF || g !== e) begin
      failures++; $display("FAIL scroll_paused got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_simultaneous;
    logic [18:0] e, g;
    do_reset;
    repeat (4) press(1, 0);
    press(1, 1);
    checks++;
    if (MODE !== 3'd5) begin
      failures++; $display("FAIL both_mode got=%0d exp=5", MODE);
    end
    repeat (2) step_px(0, 0, 1, 1, 1, e, g);
    step_px(31, 0, 1, 1, 1, e, g);
    checks++;
    if (g[18:3] !== 16'hFFFF || g !== e) begin
      failures++; $display("FAIL both_paused got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_led;
    logic [2:0] e;
    do_reset;
    for (int unsigned k = 0; k < 12; k++) begin
      if (k != 0) begin @(posedge CLK); #1; end
      case ((k % 6) / 2)
        0:       e = 3'b011;
        1:       e = 3'b101;
        default: e = 3'b110;
      endcase
      checks++;
      if ({LED_R, LED_G, LED_B} !== e) begin
        failures++; $display("FAIL led_seq k=%0d got=%b exp=%b", k, {LED_R, LED_G, LED_B}, e);
      end
    end
  endtask

  task automatic test_led_pause;
    do_reset;
    @(posedge CLK);
    press(0, 1);
    for (int unsigned k = 0; k < 15; k++) begin
      @(posedge CLK); #1;
      checks++;
      if ({LED_R, LED_G, LED_B} !== 3'b101) begin
        failures++; $display("FAIL led_pause k=%0d got=%b exp=101", k, {LED_R, LED_G, LED_B});
      end
    end
  endtask

  task automatic test_reset_midline;
    logic [18:0] e, g;
    do_reset;
    press(1, 0);
    step_px(400, 240, 1, 0, 0, e, g);
    checks++;
    if (g !== e) begin
      failures++; $display("FAIL solid_px got=%h exp=%h", g, e);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    g = {lcd_if.LCD_R, lcd_if.LCD_G, lcd_if.LCD_B, lcd_if.LCD_DE, lcd_if.LCD_HSYNC, lcd_if.LCD_VSYNC};
    checks++;
    if (g !== 19'h00003 || MODE !== 3'd0) begin
      failures++; $display("FAIL midline_reset got=%h mode=%0d exp=00003 mode=0", g, MODE);
    end
    @(negedge CLK);
    RST = 1'b0;
    mode_m = 0; scroll_m = 0; paused_m = 0;
    step_px(5, 5, 1, 1, 0, e, g);
    checks++;
    if (g[18:3] !== 16'hFFFF || g !== e) begin
      failures++; $display("FAIL resume_px got=%h exp=%h", g, e);
    end
  endtask

  initial begin
    RST = 1'b1; BTN_MODE = 1'b1; BTN_PAUSE = 1'b1;
    lcd_if.DE_IN = 1'b0; lcd_if.X_IN = '0; lcd_if.Y_IN = '0;
    lcd_if.HSYNC_IN = 1'b1; lcd_if.VSYNC_IN = 1'b1;
    repeat (2) @(posedge CLK);
    test_reset;
    test_debounce;
    test_patterns;
    test_bars;
    test_scroll;
    test_simultaneous;
    test_led;
    test_led_pause;
    test_reset_midline;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
